// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the host-side CPU run controller.
package code_pack;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } run_state_e;

    // Width of one instruction word
    localparam int INSTR_W = 9;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream plus instruction-memory write port.
// The host is the master; the controller is the slave.
interface cpu_run_ctrl_if import code_pack::*; #(
    parameter int IM_AW = 8
);
    logic               ld_valid;
    logic               ld_ready;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;
    logic               im_we;
    logic [IM_AW-1:0]   im_addr;
    logic [INSTR_W-1:0] im_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    // Count up, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side sequencer: streams a program into instruction memory,
// kicks the CPU, and times the run with a timeout guard.
module cpu_run_ctrl import code_pack::*; #(
    parameter int IM_AW   = 8,
    parameter int CW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_run_ctrl_if.slave   lb,
    input  logic            run_req,
    input  logic            abort,
    input  logic            done,
    output logic            start,
    output logic            busy,
    output logic            run_ok,
    output logic            timeout,
    output logic            err,
    output logic [IM_AW:0]  prog_len,
    output logic [CW-1:0]   cycles
);
    localparam logic [IM_AW:0]   DEPTH     = {1'b1, {IM_AW{1'b0}}};
    localparam logic [IM_AW:0]   ONE_WORD  = {{IM_AW{1'b0}}, 1'b1};
    localparam logic [IM_AW-1:0] LAST_ADDR = {IM_AW{1'b1}};
    localparam logic [CW-1:0]    TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    TO_VAL    = CW'(TIMEOUT);

    run_state_e         state, state_nxt;
    logic               rdy_en;
    logic [IM_AW:0]     wr_cnt, wr_cnt_nxt;
    logic               we_q, we_nxt;
    logic [IM_AW-1:0]   addr_q, addr_nxt;
    logic [INSTR_W-1:0] wdata_q, wdata_nxt;
    logic               start_nxt, ok_nxt, to_nxt, err_nxt, busy_nxt;
    logic [IM_AW:0]     plen_nxt;
    logic [CW-1:0]      cyc_nxt;
    logic               cnt_clr, cnt_en;
    logic [CW-1:0]      cnt;
    logic               hs;

    // rdy_en keeps ld_ready low while reset is held and for one edge after
    assign lb.ld_ready = rdy_en && ((state == IDLE) || (state == LOAD)) && !abort;
    assign hs          = lb.ld_valid && lb.ld_ready;
    assign lb.im_we    = we_q;
    assign lb.im_addr  = addr_q;
    assign lb.im_wdata = wdata_q;

    sat_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt)
    );

    // Next-state and next registered-output decode
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        we_nxt     = 1'b0;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        start_nxt  = 1'b0;
        ok_nxt     = 1'b0;
        to_nxt     = 1'b0;
        err_nxt    = 1'b0;
        plen_nxt   = prog_len;
        cyc_nxt    = cycles;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = '0;
                        wdata_nxt = lb.ld_data;
                        if (lb.ld_last) begin
                            plen_nxt = ONE_WORD;
                        end else begin
                            wr_cnt_nxt = ONE_WORD;
                            state_nxt  = LOAD;
                        end
                    end else if (run_req) begin
                        if (prog_len != '0) begin
                            state_nxt = START;
                            start_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        we_nxt     = 1'b1;
                        addr_nxt   = wr_cnt[IM_AW-1:0];
                        wdata_nxt  = lb.ld_data;
                        wr_cnt_nxt = wr_cnt + 1'b1;
                        if (lb.ld_last) begin
                            plen_nxt  = wr_cnt + 1'b1;
                            state_nxt = IDLE;
                        end else if (wr_cnt[IM_AW-1:0] == LAST_ADDR) begin
                            // Memory full without a last beat: keep what fit, flag it
                            plen_nxt  = DEPTH;
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                START: begin
                    cnt_clr   = 1'b1;
                    state_nxt = RUN;
                end
                RUN: begin
                    cnt_en = !done;
                    if (done) begin
                        cyc_nxt   = cnt;
                        ok_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == TO_LAST) begin
                        cyc_nxt   = TO_VAL;
                        to_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdy_en   <= 1'b0;
            wr_cnt   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            start    <= 1'b0;
            run_ok   <= 1'b0;
            timeout  <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            prog_len <= '0;
            cycles   <= '0;
        end else begin
            state    <= state_nxt;
            rdy_en   <= 1'b1;
            wr_cnt   <= wr_cnt_nxt;
            we_q     <= we_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            start    <= start_nxt;
            run_ok   <= ok_nxt;
            timeout  <= to_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
            prog_len <= plen_nxt;
            cycles   <= cyc_nxt;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a cycle-stamped behavioural model
// plus literal expectations at the end of each scenario.
module tb_cpu_run_ctrl;
    localparam int IM_AW   = 8;
    localparam int CW      = 16;
    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 1 << IM_AW;

    logic clk = 1'b0;
    logic rst_n;
    logic run_req, abort, done;
    logic start, busy, run_ok, timeout, err;
    logic [IM_AW:0]  prog_len;
    logic [CW-1:0]   cycles;

    cpu_run_ctrl_if #(.IM_AW(IM_AW)) lb();

    cpu_run_ctrl #(.IM_AW(IM_AW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lb       (lb),
        .run_req  (run_req),
        .abort    (abort),
        .done     (done),
        .start    (start),
        .busy     (busy),
        .run_ok   (run_ok),
        .timeout  (timeout),
        .err      (err),
        .prog_len (prog_len),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] pat(input int k);
        return 9'((k * 37 + 5) & 32'h1ff);
    endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 loading, 2 start cycle, 3 running.
    // Run length is timestamp arithmetic against the edge where RUN began.
    int         m_mode, m_words, m_now, m_t0;
    logic       m_up, m_we, m_start, m_ok, m_to, m_err;
    logic [7:0] m_addr;
    logic [8:0] m_wdata, m_plen;
    logic [15:0] m_cyc;

    initial m_now = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_words <= 0; m_t0 <= 0; m_up <= 1'b0;
            m_we <= 1'b0; m_start <= 1'b0; m_ok <= 1'b0; m_to <= 1'b0; m_err <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_plen <= '0; m_cyc <= '0;
        end else begin
            m_now   <= m_now + 1;
            m_up    <= 1'b1;
            m_we    <= 1'b0; m_start <= 1'b0; m_ok <= 1'b0; m_to <= 1'b0; m_err <= 1'b0;
            if (abort) begin
                m_mode <= 0;
            end else if (m_mode == 0) begin
                if (lb.ld_valid && m_up) begin
                    m_we <= 1'b1; m_addr <= '0; m_wdata <= lb.ld_data;
                    if (lb.ld_last) m_plen <= 9'd1;
                    else begin m_mode <= 1; m_words <= 1; end
                end else if (run_req) begin
                    if (m_plen != 0) begin m_mode <= 2; m_start <= 1'b1; end
                    else m_err <= 1'b1;
                end
            end else if (m_mode == 1) begin
                if (lb.ld_valid) begin
                    m_we <= 1'b1; m_addr <= 8'(m_words); m_wdata <= lb.ld_data;
                    m_words <= m_words + 1;
                    if (lb.ld_last) begin
                        m_plen <= 9'(m_words + 1); m_mode <= 0;
                    end else if (m_words + 1 == DEPTH) begin
                        m_plen <= 9'(DEPTH); m_err <= 1'b1; m_mode <= 0;
                    end
                end
            end else if (m_mode == 2) begin
                m_mode <= 3;
                m_t0   <= m_now + 1;
            end else begin
                if (done) begin
                    m_cyc <= 16'(m_now - m_t0); m_ok <= 1'b1; m_mode <= 0;
                end else if (m_now - m_t0 == TIMEOUT - 1) begin
                    m_cyc <= 16'(TIMEOUT); m_to <= 1'b1; m_mode <= 0;
                end
            end
        end
    end

    // ---------------- compare + event tallies ----------------
    logic [8:0] tb_mem [DEPTH];
    int we_cnt = 0, err_cnt = 0, ok_cnt = 0, to_cnt = 0, start_cnt = 0;
    logic exp_rdy;

    always @(negedge clk) begin
        exp_rdy = m_up && (m_mode < 2) && !abort;
        chk("ctrl{rdy,we,start,busy,ok,to,err}",
            {lb.ld_ready, lb.im_we, start, busy, run_ok, timeout, err},
            {exp_rdy, m_we, m_start, (m_mode != 0), m_ok, m_to, m_err});
        if (m_we)
            chk("wport{addr,data}", {lb.im_addr, lb.im_wdata}, {m_addr, m_wdata});
        chk("regs{prog_len,cycles}", {prog_len, cycles}, {m_plen, m_cyc});
        if (rst_n) begin
            if (lb.im_we) begin tb_mem[lb.im_addr] = lb.im_wdata; we_cnt++; end
            if (err)     err_cnt++;
            if (run_ok)  ok_cnt++;
            if (timeout) to_cnt++;
            if (start)   start_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int n, input bit last, input int base, input bit rq);
        for (int i = 0; i < n; i++) begin
            int w;
            lb.ld_valid = 1'b1;
            lb.ld_data  = pat(base + i);
            lb.ld_last  = last && (i == n - 1);
            run_req     = rq && (i == 0);
            w = 0;
            while (!lb.ld_ready && w < 20) begin tick(); w++; end
            if (w == 20) begin
                total++; bad++;
                $display("FAIL ready_wait actual=0 expected=1 beat=%0d", i);
            end
            tick();
        end
        lb.ld_valid = 1'b0;
        lb.ld_last  = 1'b0;
        run_req     = 1'b0;
    endtask

    task automatic memchk(input string nm, input int n, input int base);
        int miss;
        miss = 0;
        for (int i = 0; i < n; i++)
            if (tb_mem[i] !== pat(base + i)) miss++;
        chk(nm, miss, 0);
    endtask

    task automatic kick_run();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; run_req = 1'b0; abort = 1'b0; done = 1'b0;
        lb.ld_valid = 1'b0; lb.ld_data = '0; lb.ld_last = 1'b0;
        repeat (3) tick();
        chk("rst_ld_ready", lb.ld_ready, 0);
        chk("rst_prog_len", prog_len, 0);
        rst_n = 1'b1;
        chk("rel_ld_ready_low", lb.ld_ready, 0);
        tick();
        chk("rel_ld_ready_high", lb.ld_ready, 1);

        // run with nothing loaded
        run_req = 1'b1; tick(); run_req = 1'b0;
        repeat (3) tick();
        chk("empty_run_err", err_cnt, 1);
        chk("empty_run_nostart", start_cnt, 0);

        // 25-beat program
        send(25, 1'b1, 0, 1'b0);
        repeat (2) tick();
        chk("load25_prog_len", prog_len, 25);
        chk("load25_we_cnt", we_cnt, 25);
        chk("load25_no_err", err_cnt, 1);
        memchk("load25_mem", 25, 0);

        // run, done 40 cycles into RUN
        kick_run();
        repeat (40) tick();
        done = 1'b1; tick(); done = 1'b0;
        tick();
        chk("run40_cycles", cycles, 40);
        chk("run40_ok", ok_cnt, 1);
        chk("run40_start", start_cnt, 1);

        // timeout
        kick_run();
        repeat (70) tick();
        chk("to_cycles", cycles, TIMEOUT);
        chk("to_pulse", to_cnt, 1);
        chk("to_busy", busy, 0);

        // ld_valid and run_req together: load wins
        send(3, 1'b1, 300, 1'b1);
        repeat (2) tick();
        chk("race_prog_len", prog_len, 3);
        chk("race_nostart", start_cnt, 2);

        // overflow: full memory without last
        send(DEPTH, 1'b0, 500, 1'b0);
        repeat (2) tick();
        chk("ovf_prog_len", prog_len, DEPTH);
        chk("ovf_err", err_cnt, 2);
        chk("ovf_we_cnt", we_cnt, 25 + 3 + DEPTH);
        memchk("ovf_mem", DEPTH, 500);

        // abort in RUN cycle 10
        kick_run();
        repeat (10) tick();
        abort = 1'b1;
        chk("abort_ld_ready", lb.ld_ready, 0);
        tick(); abort = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_cycles", cycles, TIMEOUT);
        chk("abort_no_pulse", ok_cnt + to_cnt, 2);

        // reset mid-LOAD
        send(5, 1'b0, 900, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {lb.ld_ready, lb.im_we, start, busy, run_ok, timeout, err}, 0);
        chk("mid_rst_regs", {prog_len, cycles}, 0);
        tick(); tick();
        rst_n = 1'b1;
        chk("mid_rel_ready_low", lb.ld_ready, 0);
        tick();
        chk("mid_rel_ready_high", lb.ld_ready, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Host-side sequencer for the 9-bit CPU. It streams a program into instruction memory over a valid/ready handshake, then pulses `start` to `top_level` and waits for `done`. It measures run length in clock cycles and aborts with a timeout if `done` never arrives. It sits between the host/test harness and `top_level`, driving the instruction-memory write port and the CPU `start` line.

## Interface
- `IM_AW`, 8: instruction-memory address width; depth = 2**IM_AW.
- `CW`, 16: cycle-counter width.
- `TIMEOUT`, 4096: maximum RUN cycles before abort; must be ≥1 and < 2**CW.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ld_valid`  in  1  program beat valid.
- `ld_ready`  out  1  controller accepts a beat.
- `ld_data`  in  9  instruction word.
- `ld_last`  in  1  final beat of program.
- `run_req`  in  1  single-cycle request to execute the loaded program.
- `abort`  in  1  force return to IDLE.
- `im_we`  out  1  instruction-memory write enable.
- `im_addr`  out  IM_AW  write address.
- `im_wdata`  out  9  write data.
- `start`  out  1  to `top_level.start`.
- `done`  in  1  from `top_level.done`.
- `busy`  out  1  state ≠ IDLE.
- `run_ok`  out  1  one-cycle pulse when `done` is seen.
- `timeout`  out  1  one-cycle pulse on timeout.
- `err`  out  1  one-cycle pulse on load overflow or run with an empty program.
- `prog_len`  out  IM_AW+1  words in the last completed load.
- `cycles`  out  CW  length of the last completed run.

## Operation
- States: IDLE, LOAD, START, RUN. Encoding is held in a package enum.
- **IDLE:** `ld_ready`=1.
  - `ld_valid`: accept the beat at address 0 and go to LOAD. If `ld_last` is also high, finish the load immediately (prog_len=1) and stay in IDLE.
  - `run_req` with prog_len≠0: go to START.
  - `run_req` with prog_len=0: pulse `err` and stay in IDLE.
  - `ld_valid` and `run_req` together: load wins and `run_req` is dropped.
- **LOAD:** `ld_ready`=1. Each handshake writes the next sequential address.
  - `ld_last`: set prog_len = words written and go to IDLE.
  - Beat written at address 2**IM_AW−1 without `ld_last`: accept it, set prog_len=2**IM_AW, pulse `err`, go to IDLE.
  - `run_req` is ignored.
- **START:** `start`=1 for exactly one cycle. Clear the cycle counter and go to RUN. `done` is ignored here (stale from a previous run).
- **RUN:** each cycle with `done`=0 increments the counter, saturating at all-ones.
  - `done`=1: latch the counter into `cycles`, pulse `run_ok`, go to IDLE.
  - Counter = TIMEOUT−1 with `done`=0: latch TIMEOUT into `cycles`, pulse `timeout`, go to IDLE.
- **abort:** from any state, go to IDLE on the next edge.
  - `start` and `im_we` drop.
  - No pulse is generated.
  - `prog_len` and `cycles` keep their old values; a partial load does not update `prog_len`.
- `ld_ready`=0 in START/RUN and in the cycle `abort` is high.

## Timing
- Reset values:
  - state = IDLE.
  - `ld_ready`, `start`, `im_we`, `run_ok`, `timeout`, `err`, `busy` = 0.
  - `im_addr`, `im_wdata`, `prog_len`, `cycles` = 0.
  - `ld_ready` rises the first cycle after `rst_n` deasserts.
- All outputs are registered except `ld_ready`, which decodes directly from state and `abort`.
- Beat accepted at edge n: `im_we`/`im_addr`/`im_wdata` valid during cycle n+1, one write per cycle. Back-to-back beats are sustained at full rate.
- `run_req` sampled at edge n: `start` is high during cycle n+1 and RUN begins at cycle n+2.
- `cycles` counts RUN cycles before `done`; `done` in the first RUN cycle gives `cycles`=0.
- `run_ok`/`timeout`/`err` are high for exactly one cycle, coincident with the return to IDLE. `cycles`/`prog_len` update on the same edge.
- Reset asserted mid-LOAD or mid-RUN clears all state asynchronously. Instruction-memory contents are not touched.

## Structure
- In `code_pack`:
  - `run_state_e` enum (IDLE, LOAD, START, RUN).
  - `INSTR_W`=9 constant, which `ld_data`/`im_wdata` use.
- One sub-module, `sat_counter`: CW-wide, with synchronous clear, enable and saturation, and an async active-low reset. It is used for the RUN cycle count.
- Write-address generation and the FSM stay in `cpu_run_ctrl`.

## Test plan
- Reset, then load 25 beats (last on beat 25) -> 25 consecutive `im_we` at addresses 0..24 with matching data; prog_len=25; `err`=0.
- `run_req` after load; model drives `done` 40 cycles into RUN -> `start` high exactly one cycle; `run_ok` pulse; `cycles`=40.
- `run_req` with `done` held low, TIMEOUT=64 -> `timeout` pulse after 64 RUN cycles; `cycles`=64; `busy`=0 next cycle.
- Load 256 beats with no `ld_last` (IM_AW=8) -> all 256 written; prog_len=256; `err` pulse on the last accept.
- `run_req` right after reset -> `err` pulse; no `start`. Same-cycle `ld_valid`+`run_req` in IDLE -> load proceeds and no `start`.
- `abort` in cycle 10 of RUN, then `rst_n` low mid-LOAD -> IDLE with `cycles` unchanged; after reset all outputs are 0 and `ld_ready` returns to 1.
